// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default widths, ID/EX sequencing states and
// the control bundle that travels from ID into EX.
package cpu_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } idex_state_e;

   typedef struct packed {
      logic       valid;
      logic       ru_wr;
      logic       dm_rd;
      logic       dm_wr;
      logic [3:0] alu_op;
   } idex_ctrl_t;

   // A bubble is a slot that neither writes anything nor touches memory.
   function automatic idex_ctrl_t ctrl_bubble();
      return '0;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose destination
// is read by the instruction currently in ID.
module hazard_detect (
   input  logic       valid_ex,
   input  logic       ld_ex,
   input  logic       wr_ex,
   input  logic [4:0] rd_ex,
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic       use_rs1_id,
   input  logic       use_rs2_id,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = use_rs1_id && (rs1_id == rd_ex);
   assign rs2_hit  = use_rs2_id && (rs2_id == rd_ex);
   // x0 never carries a real result, so a load into it cannot create a hazard.
   assign load_use = valid_ex && ld_ex && wr_ex && (rd_ex != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, external hold, load-use bubble insertion
// and saturating stall/flush event counters.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_id,
   input  logic [XLEN-1:0]  pc_id,
   input  logic [XLEN-1:0]  imm_id,
   input  logic [XLEN-1:0]  ru_rs1_id,
   input  logic [XLEN-1:0]  ru_rs2_id,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic [4:0]       rd_id,
   input  logic             use_rs1_id,
   input  logic             use_rs2_id,
   input  logic             RUWr_id,
   input  logic             DMRd_id,
   input  logic             DMWr_id,
   input  logic [3:0]       alu_op_id,
   input  logic             flush_ex,
   input  logic             hold,
   output logic [XLEN-1:0]  pc_ex,
   output logic [XLEN-1:0]  imm_ex,
   output logic [XLEN-1:0]  ru_rs1_ex,
   output logic [XLEN-1:0]  ru_rs2_ex,
   output logic [4:0]       rs1_ex,
   output logic [4:0]       rs2_ex,
   output logic [4:0]       rd_ex,
   output logic             RUWr_ex,
   output logic             DMRd_ex,
   output logic             DMWr_ex,
   output logic             valid_ex,
   output logic [3:0]       alu_op_ex,
   output logic             stall_if_id,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   idex_state_e state;
   idex_ctrl_t  ctrl_ex;
   idex_ctrl_t  ctrl_id;
   logic        load_use;
   logic        clear;

   hazard_detect u_hazard (
      .valid_ex   (ctrl_ex.valid),
      .ld_ex      (ctrl_ex.dm_rd),
      .wr_ex      (ctrl_ex.ru_wr),
      .rd_ex      (rd_ex),
      .rs1_id     (rs1_id),
      .rs2_id     (rs2_id),
      .use_rs1_id (use_rs1_id),
      .use_rs2_id (use_rs2_id),
      .load_use   (load_use)
   );

   // In BUBBLE the EX slot is empty, so the state gate only makes that explicit.
   assign stall_if_id = load_use && (state == RUN) && !flush_ex && !hold;
   assign clear       = !rst_n || flush_ex || stall_if_id;

   always_comb begin
      ctrl_id        = ctrl_bubble();
      ctrl_id.valid  = valid_id;
      ctrl_id.ru_wr  = valid_id && RUWr_id && (rd_id != 5'd0);
      ctrl_id.dm_rd  = valid_id && DMRd_id;
      ctrl_id.dm_wr  = valid_id && DMWr_id;
      ctrl_id.alu_op = alu_op_id;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         pc_ex     <= '0;
         imm_ex    <= '0;
         ru_rs1_ex <= '0;
         ru_rs2_ex <= '0;
         rs1_ex    <= '0;
         rs2_ex    <= '0;
         rd_ex     <= '0;
         ctrl_ex   <= ctrl_bubble();
      end else if (!hold) begin
         pc_ex     <= pc_id;
         imm_ex    <= imm_id;
         ru_rs1_ex <= ru_rs1_id;
         ru_rs2_ex <= ru_rs2_id;
         rs1_ex    <= rs1_id;
         rs2_ex    <= rs2_id;
         rd_ex     <= rd_id;
         ctrl_ex   <= ctrl_id;
      end
   end

   // Sequencing state and event counters; a flush outranks a coincident load-use.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush_ex) begin
         state     <= RUN;
         flush_cnt <= (flush_cnt == '1) ? flush_cnt : flush_cnt + 1'b1;
      end else if (!hold) begin
         if (stall_if_id) begin
            state     <= BUBBLE;
            stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
         end else begin
            state <= RUN;
         end
      end
   end

   assign valid_ex  = ctrl_ex.valid;
   assign RUWr_ex   = ctrl_ex.ru_wr;
   assign DMRd_ex   = ctrl_ex.dm_rd;
   assign DMWr_ex   = ctrl_ex.dm_wr;
   assign alu_op_ex = ctrl_ex.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_id_ex_stage;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, valid_id, flush_ex, hold;
   logic [XLEN-1:0] pc_id, imm_id, ru_rs1_id, ru_rs2_id;
   logic [4:0]      rs1_id, rs2_id, rd_id;
   logic            use_rs1_id, use_rs2_id, RUWr_id, DMRd_id, DMWr_id;
   logic [3:0]      alu_op_id;

   logic [XLEN-1:0]  pc_ex, imm_ex, ru_rs1_ex, ru_rs2_ex;
   logic [4:0]       rs1_ex, rs2_ex, rd_ex;
   logic             RUWr_ex, DMRd_ex, DMWr_ex, valid_ex, stall_if_id;
   logic [3:0]       alu_op_ex;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // Reference model of the EX slot contents and the two event counters.
   logic [XLEN-1:0] e_pc, e_imm, e_a, e_b;
   logic [4:0]      e_rs1, e_rs2, e_rd;
   logic            e_valid, e_ruwr, e_dmrd, e_dmwr;
   logic [3:0]      e_alu;
   int              e_stall_cnt, e_flush_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
      .pc_id(pc_id), .imm_id(imm_id), .ru_rs1_id(ru_rs1_id), .ru_rs2_id(ru_rs2_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
      .RUWr_id(RUWr_id), .DMRd_id(DMRd_id), .DMWr_id(DMWr_id), .alu_op_id(alu_op_id),
      .flush_ex(flush_ex), .hold(hold),
      .pc_ex(pc_ex), .imm_ex(imm_ex), .ru_rs1_ex(ru_rs1_ex), .ru_rs2_ex(ru_rs2_ex),
      .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
      .RUWr_ex(RUWr_ex), .DMRd_ex(DMRd_ex), .DMWr_ex(DMWr_ex), .valid_ex(valid_ex),
      .alu_op_ex(alu_op_ex), .stall_if_id(stall_if_id),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      e_pc = '0; e_imm = '0; e_a = '0; e_b = '0;
      e_rs1 = '0; e_rs2 = '0; e_rd = '0;
      e_valid = 1'b0; e_ruwr = 1'b0; e_dmrd = 1'b0; e_dmwr = 1'b0; e_alu = '0;
   endtask

   // One clock: check the stall request, clock the edge, update the model, check EX.
   task automatic applyStimulus();
      logic reads_load, exp_stall;
      #1;
      reads_load = (use_rs1_id && rs1_id == e_rd) || (use_rs2_id && rs2_id == e_rd);
      exp_stall  = e_valid && e_dmrd && e_ruwr && (e_rd != 5'd0) && reads_load && !flush_ex && !hold;
      checkOutput("stall_if_id", 64'(stall_if_id), 64'(exp_stall));
      @(posedge clk);
      if (!rst_n) begin
         modelClear();
         e_stall_cnt = 0;
         e_flush_cnt = 0;
      end else if (flush_ex) begin
         modelClear();
         if (e_flush_cnt < CNT_MAX) e_flush_cnt++;
      end else if (hold) begin
         e_pc = e_pc;
      end else if (exp_stall) begin
         modelClear();
         if (e_stall_cnt < CNT_MAX) e_stall_cnt++;
      end else begin
         e_pc = pc_id; e_imm = imm_id; e_a = ru_rs1_id; e_b = ru_rs2_id;
         e_rs1 = rs1_id; e_rs2 = rs2_id; e_rd = rd_id; e_alu = alu_op_id;
         e_valid = valid_id;
         e_ruwr  = valid_id && RUWr_id && (rd_id != 5'd0);
         e_dmrd  = valid_id && DMRd_id;
         e_dmwr  = valid_id && DMWr_id;
      end
      #1;
      checkOutput("pc_ex", 64'(pc_ex), 64'(e_pc));
      checkOutput("imm_ex", 64'(imm_ex), 64'(e_imm));
      checkOutput("ru_rs1_ex", 64'(ru_rs1_ex), 64'(e_a));
      checkOutput("ru_rs2_ex", 64'(ru_rs2_ex), 64'(e_b));
      checkOutput("rs1_ex", 64'(rs1_ex), 64'(e_rs1));
      checkOutput("rs2_ex", 64'(rs2_ex), 64'(e_rs2));
      checkOutput("rd_ex", 64'(rd_ex), 64'(e_rd));
      checkOutput("valid_ex", 64'(valid_ex), 64'(e_valid));
      checkOutput("RUWr_ex", 64'(RUWr_ex), 64'(e_ruwr));
      checkOutput("DMRd_ex", 64'(DMRd_ex), 64'(e_dmrd));
      checkOutput("DMWr_ex", 64'(DMWr_ex), 64'(e_dmwr));
      checkOutput("alu_op_ex", 64'(alu_op_ex), 64'(e_alu));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(e_stall_cnt));
      checkOutput("flush_cnt", 64'(flush_cnt), 64'(e_flush_cnt));
   endtask

   task automatic driveInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic wr, input logic ld, input logic st);
      valid_id  = 1'b1;
      pc_id     = $urandom();
      imm_id    = $urandom();
      ru_rs1_id = $urandom();
      ru_rs2_id = $urandom();
      alu_op_id = 4'($urandom());
      rs1_id = rs1; rs2_id = rs2; rd_id = rd;
      use_rs1_id = u1; use_rs2_id = u2;
      RUWr_id = wr; DMRd_id = ld; DMWr_id = st;
   endtask

   initial begin
      modelClear();
      e_stall_cnt = 0;
      e_flush_cnt = 0;
      rst_n = 1'b0; flush_ex = 1'b1; hold = 1'b1;
      driveInstr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      $display("[TB] reset overriding flush and hold");
      repeat (2) applyStimulus();
      checkOutput("reset_valid", 64'(valid_ex), 64'd0);
      rst_n = 1'b1; flush_ex = 1'b0; hold = 1'b0;

      $display("[TB] capture of add rd=5");
      driveInstr(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkOutput("capture_rd", 64'(rd_ex), 64'd5);

      $display("[TB] load-use on rs1");
      driveInstr(5'd2, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus();
      driveInstr(5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkOutput("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);
      applyStimulus();
      checkOutput("loaduse_captured_rd", 64'(rd_ex), 64'd8);

      $display("[TB] x0 destination");
      driveInstr(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus();
      driveInstr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkOutput("x0_ruwr", 64'(RUWr_ex), 64'd0);

      $display("[TB] flush against load-use");
      driveInstr(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus();
      driveInstr(5'd4, 5'd9, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      flush_ex = 1'b1;
      applyStimulus();
      checkOutput("flush_cnt_one", 64'(flush_cnt), 64'd1);
      flush_ex = 1'b0;

      $display("[TB] hold with changing inputs, then hold with flush");
      driveInstr(5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         driveInstr(5'($urandom()), 5'($urandom()), 5'($urandom()), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         applyStimulus();
      end
      checkOutput("hold_rd", 64'(rd_ex), 64'd13);
      flush_ex = 1'b1;
      applyStimulus();
      flush_ex = 1'b0; hold = 1'b0;

      $display("[TB] reset during bubble and during hold");
      driveInstr(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus();
      driveInstr(5'd6, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      rst_n = 1'b0; hold = 1'b1;
      applyStimulus();
      rst_n = 1'b1;
      applyStimulus();
      hold = 1'b0;

      $display("[TB] flush counter saturation");
      flush_ex = 1'b1;
      for (int i = 0; i < 17; i++) begin
         driveInstr(5'($urandom()), 5'($urandom()), 5'($urandom()), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         applyStimulus();
      end
      checkOutput("flush_cnt_sat", 64'(flush_cnt), 64'd15);
      flush_ex = 1'b0;

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         rst_n     = ($urandom_range(0, 79) != 0);
         flush_ex  = ($urandom_range(0, 9) == 0);
         hold      = ($urandom_range(0, 6) == 0);
         valid_id  = ($urandom_range(0, 7) != 0);
         pc_id     = $urandom();
         imm_id    = $urandom();
         ru_rs1_id = $urandom();
         ru_rs2_id = $urandom();
         alu_op_id = 4'($urandom());
         rs1_id    = 5'($urandom_range(0, 5));
         rs2_id    = 5'($urandom_range(0, 5));
         rd_id     = 5'($urandom_range(0, 5));
         use_rs1_id = ($urandom_range(0, 3) != 0);
         use_rs2_id = ($urandom_range(0, 1) != 0);
         RUWr_id   = ($urandom_range(0, 4) != 0);
         DMRd_id   = ($urandom_range(0, 1) != 0);
         DMWr_id   = !DMRd_id && ($urandom_range(0, 3) == 0);
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-005 valid_id  in  1  ID holds a real instruction.
REQ-006 pc_id, imm_id, ru_rs1_id, ru_rs2_id  in  XLEN each  PC, immediate, register-file read values.
REQ-007 rs1_id, rs2_id, rd_id  in  5 each  register indices.
REQ-008 use_rs1_id, use_rs2_id  in  1 each  instruction actually reads rs1/rs2.
REQ-009 RUWr_id, DMRd_id, DMWr_id  in  1 each  regfile write, load, store.
REQ-010 alu_op_id  in  4  ALU operation code.
REQ-011 flush_ex  in  1  taken branch/jump resolved in EX; kill ID/EX contents.
REQ-012 hold  in  1  external freeze (memory busy); register keeps contents.
REQ-013 Outputs pc_ex, imm_ex, ru_rs1_ex, ru_rs2_ex (XLEN), rs1_ex, rs2_ex, rd_ex (5), RUWr_ex, DMRd_ex, DMWr_ex, valid_ex (1), alu_op_ex (4): registered EX-stage copies feeding forwarding unit and ALU.
REQ-014 stall_if_id  out  1  combinational; freeze PC and IF/ID register this cycle.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-016 Load-use hazard SHALL be: valid_ex & DMRd_ex & RUWr_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
REQ-017 stall_if_id SHALL equal load_use & ~flush_ex & ~hold.
REQ-018 Per-edge priority SHALL be: reset > flush_ex > hold > load-use bubble > capture.
REQ-019 flush_ex SHALL load a bubble: valid_ex, RUWr_ex, DMRd_ex, DMWr_ex =0; all other outputs of the register =0.
REQ-020 hold (no flush) SHALL leave every registered output unchanged.
REQ-021 Load-use SHALL load a bubble identical to REQ-019 and move FSM to BUBBLE.
REQ-022 Capture SHALL copy all *_id fields to *_ex with 1-cycle latency.
REQ-023 On capture, RUWr_ex SHALL be 0 when rd_id==0 or valid_id==0; DMRd_ex, DMWr_ex SHALL be 0 when valid_id==0.
REQ-024 FSM states RUN, BUBBLE: RUN->BUBBLE on load-use bubble; BUBBLE->RUN on next non-hold edge; BUBBLE stays while hold.
REQ-025 In BUBBLE, load-use SHALL be impossible (EX holds a bubble); stall_if_id SHALL be 0.
REQ-026 stall_cnt SHALL increment by 1 on every edge a load-use bubble is loaded; saturate at all-ones.
REQ-027 flush_cnt SHALL increment by 1 on every edge flush_ex is applied; saturate at all-ones.
REQ-028 Simultaneous flush_ex and load-use SHALL count only flush; stall_cnt unchanged.

Reset
REQ-029 rst_n=0 at an edge SHALL force all registered outputs to 0, FSM to RUN, both counters to 0, overriding flush_ex and hold.
REQ-030 Reset asserted mid-BUBBLE or mid-hold SHALL leave no residual state; stall_if_id SHALL be 0 while outputs are reset values.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN default, idex_state_e enum (RUN, BUBBLE) and the ID/EX control-bundle struct.
REQ-032 Load-use comparison SHALL be a combinational sub-module hazard_detect; registers and FSM in id_ex_stage.

Verification
REQ-033 Capture: valid add rd=5, RUWr=1 -> next cycle rd_ex=5, RUWr_ex=1, valid_ex=1, all fields copied.
REQ-034 Load-use: EX holds lw rd=7; ID add rs1=7 use_rs1=1 -> stall_if_id=1, next edge bubble, stall_cnt=1, FSM BUBBLE; following edge add captured, FSM RUN.
REQ-035 x0: lw rd=0 in EX, ID rs1=0 -> no stall; capture rd_id=0, RUWr_id=1 -> RUWr_ex=0.
REQ-036 Flush vs load-use: hazard present plus flush_ex=1 -> stall_if_id=0, bubble, flush_cnt=1, stall_cnt=0.
REQ-037 Hold: hold=1 for 3 cycles with changing ID inputs -> outputs constant; hold with flush_ex=1 -> bubble.
REQ-038 Saturation/reset: CNT_W=4, 17 flushes -> flush_cnt=15; rst_n=0 during hold -> all outputs 0, FSM RUN.
